// File: rtl/hilo_acc_if.sv
// HI/LO accumulate unit bus: direct writes, accumulate issue, flush and forwarded reads.
interface hilo_acc_if #(
  parameter int W = 32
);
  logic         we_hi;
  logic         we_lo;
  logic [W-1:0] wdata_hi;
  logic [W-1:0] wdata_lo;
  logic         acc_valid;
  logic [1:0]   acc_op;
  logic [W-1:0] acc_a;
  logic [W-1:0] acc_b;
  logic         flush;
  logic [W-1:0] rd_hi;
  logic [W-1:0] rd_lo;
  logic         busy;

  modport master (
    output we_hi, we_lo, wdata_hi, wdata_lo, acc_valid, acc_op, acc_a, acc_b, flush,
    input  rd_hi, rd_lo, busy
  );

  modport slave (
    input  we_hi, we_lo, wdata_hi, wdata_lo, acc_valid, acc_op, acc_a, acc_b, flush,
    output rd_hi, rd_lo, busy
  );
endinterface

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with a 2-stage multiply-accumulate path (multiply, then add/sub)
// and forwarded reads of the post-edge register value.
module hilo_acc_unit #(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  hilo_acc_if.slave  bus
);
  logic [W-1:0]   hi_q, lo_q;
  logic           s1_valid;
  logic [2*W-1:0] prod_q;
  logic           sub_q;

  logic           issue;
  logic           commit;
  logic [2*W-1:0] a_ext, b_ext;
  logic [2*W-1:0] prod_d;
  logic [2*W-1:0] sum;
  logic [W-1:0]   hi_d, lo_d;

  assign issue  = bus.acc_valid & ~bus.flush;
  assign commit = s1_valid & ~bus.flush;

  // acc_op[0] selects unsigned; truncating the 2W-bit product is exact either way
  always_comb begin
    a_ext = bus.acc_op[0] ? {{W{1'b0}}, bus.acc_a} : {{W{bus.acc_a[W-1]}}, bus.acc_a};
    b_ext = bus.acc_op[0] ? {{W{1'b0}}, bus.acc_b} : {{W{bus.acc_b[W-1]}}, bus.acc_b};
    prod_d = a_ext * b_ext;
  end

  always_comb begin
    sum = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = sum[2*W-1:W];
      lo_d = sum[W-1:0];
    end
    // direct writes are program-later than the in-flight commit
    if (bus.we_hi) hi_d = bus.wdata_hi;
    if (bus.we_lo) lo_d = bus.wdata_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      s1_valid <= 1'b0;
      prod_q   <= '0;
      sub_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      s1_valid <= issue;
      if (issue) begin
        prod_q <= prod_d;
        sub_q  <= bus.acc_op[1];
      end
    end
  end

  assign bus.rd_hi = hi_d;
  assign bus.rd_lo = lo_d;
  assign bus.busy  = s1_valid;
endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit: expected HI/LO/busy per cycle go through a scoreboard queue.
module tb_hilo_acc_unit;
  logic clk = 1'b0;
  logic rst_n;

  hilo_acc_if #(.W(32)) bus ();

  hilo_acc_unit #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic idle();
    bus.we_hi = 1'b0; bus.we_lo = 1'b0;
    bus.wdata_hi = '0; bus.wdata_lo = '0;
    bus.acc_valid = 1'b0; bus.acc_op = 2'b00;
    bus.acc_a = '0; bus.acc_b = '0;
    bus.flush = 1'b0;
  endtask

  // push expectation for the cycle being driven, compare mid-cycle, then advance
  task automatic cyc(input string tag, input logic [31:0] hi, input logic [31:0] lo, input logic busy);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo; e.busy = busy;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    assert (bus.rd_hi === e.hi) else begin
      n_fail++;
      $error("FAIL %s rd_hi got %h exp %h", e.tag, bus.rd_hi, e.hi);
    end
    n_tests++;
    assert (bus.rd_lo === e.lo) else begin
      n_fail++;
      $error("FAIL %s rd_lo got %h exp %h", e.tag, bus.rd_lo, e.lo);
    end
    n_tests++;
    assert (bus.busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy got %b exp %b", e.tag, bus.busy, e.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] hi, input logic [31:0] lo);
    idle();
    bus.we_hi = 1'b1; bus.wdata_hi = hi;
    bus.we_lo = 1'b1; bus.wdata_lo = lo;
    cyc("load", hi, lo, 1'b0);
    idle();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.acc_valid = 1'b1; bus.acc_op = op; bus.acc_a = a; bus.acc_b = b;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    issue(2'b00, 32'd7, 32'd7);
    @(posedge clk); #1;
    cyc("reset", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    idle();
    cyc("post_reset", 32'h0, 32'h0, 1'b0);
    cyc("post_reset_hold", 32'h0, 32'h0, 1'b0);

    // direct write forwarding and hold
    bus.we_hi = 1'b1; bus.wdata_hi = 32'h12345678;
    cyc("wr_hi_fwd", 32'h12345678, 32'h0, 1'b0);
    idle();
    cyc("wr_hi_hold", 32'h12345678, 32'h0, 1'b0);

    // back-to-back MADD then MADDU
    load(32'h0, 32'h0);
    issue(2'b00, 32'hFFFFFFFF, 32'd2);
    cyc("madd_issue", 32'h0, 32'h0, 1'b0);
    issue(2'b01, 32'hFFFFFFFF, 32'd2);
    cyc("madd_commit", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    idle();
    cyc("maddu_commit", 32'h00000001, 32'hFFFFFFFC, 1'b1);
    cyc("b2b_hold", 32'h00000001, 32'hFFFFFFFC, 1'b0);

    // MSUB
    load(32'h0, 32'h0);
    issue(2'b10, 32'd3, 32'd4);
    cyc("msub_issue", 32'h0, 32'h0, 1'b0);
    idle();
    cyc("msub_commit", 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b1);
    cyc("msub_hold", 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0);

    // MSUBU: 0 - 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFF_FFFFFFFF - 0xFFFFFFFE_00000001 + 1
    load(32'h0, 32'h0);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cyc("msubu_issue", 32'h0, 32'h0, 1'b0);
    idle();
    cyc("msubu_commit", 32'h00000001, 32'hFFFFFFFF, 1'b1);

    // flush in commit cycle
    load(32'h0, 32'h10);
    issue(2'b00, 32'd5, 32'd5);
    cyc("flush_s1_issue", 32'h0, 32'h10, 1'b0);
    idle();
    bus.flush = 1'b1;
    cyc("flush_s1_kill", 32'h0, 32'h10, 1'b1);
    idle();
    cyc("flush_s1_after", 32'h0, 32'h10, 1'b0);

    // flush in issue cycle
    issue(2'b00, 32'd5, 32'd5);
    bus.flush = 1'b1;
    cyc("flush_issue", 32'h0, 32'h10, 1'b0);
    idle();
    cyc("flush_issue_after", 32'h0, 32'h10, 1'b0);

    // flush does not block a direct write
    bus.flush = 1'b1; bus.we_hi = 1'b1; bus.wdata_hi = 32'hDEADBEEF;
    cyc("flush_wr", 32'hDEADBEEF, 32'h10, 1'b0);
    idle();
    cyc("flush_wr_hold", 32'hDEADBEEF, 32'h10, 1'b0);

    // direct write colliding with commit
    load(32'h0, 32'h0);
    issue(2'b00, 32'd2, 32'd3);
    cyc("coll_issue", 32'h0, 32'h0, 1'b0);
    idle();
    bus.we_lo = 1'b1; bus.wdata_lo = 32'hAAAA5555;
    cyc("coll_commit", 32'h0, 32'hAAAA5555, 1'b1);
    idle();
    cyc("coll_hold", 32'h0, 32'hAAAA5555, 1'b0);

    // collision on HI: LO takes the commit sum
    load(32'h0, 32'h0);
    issue(2'b00, 32'd2, 32'd3);
    cyc("coll_hi_issue", 32'h0, 32'h0, 1'b0);
    idle();
    bus.we_hi = 1'b1; bus.wdata_hi = 32'h5A5A0000;
    cyc("coll_hi_commit", 32'h5A5A0000, 32'h6, 1'b1);
    idle();
    cyc("coll_hi_hold", 32'h5A5A0000, 32'h6, 1'b0);

    // reset discards an op mid-pipeline
    issue(2'b00, 32'd1, 32'd1);
    cyc("rst_mid_issue", 32'h5A5A0000, 32'h6, 1'b0);
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("rst_mid_after", 32'h0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
- Parametrised HI/LO register unit for the integer pipeline; successor to the single 64-bit HI/LO register.
- Adds independent HI and LO write enables for MTHI/MTLO and MULT/DIV results.
- Adds a 2-stage multiply-accumulate path for MADD, MADDU, MSUB and MSUBU, with flush and full read forwarding.
- Sits beside the register file; written from the WB stage, read from EX.

Parameters:
W, 32, width of each half (HI and LO); the full accumulator is 2W bits.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
we_hi  in  1  direct write of HI this cycle
we_lo  in  1  direct write of LO this cycle
wdata_hi  in  W  HI write data
wdata_lo  in  W  LO write data
acc_valid  in  1  issue an accumulate op this cycle
acc_op  in  2  00 MADD (signed), 01 MADDU, 10 MSUB (signed), 11 MSUBU
acc_a  in  W  multiplicand
acc_b  in  W  multiplier
flush  in  1  kill any accumulate in stage 1, and any issued this cycle
rd_hi  out  W  forwarded HI value
rd_lo  out  W  forwarded LO value
busy  out  1  an accumulate is in flight (stage 1 valid)

Behaviour:
- Reset: on the rising clk edge with rst_n=0:
  - HI=0, LO=0.
  - Stage-1 valid=0, product register=0, op register=0.
  - busy=0.
  - rd_hi and rd_lo therefore read 0 once no write is presented.
- Reset overrides all other inputs, including an op mid-pipeline, which is discarded.
- Stage 1 (issue cycle N):
  - If acc_valid=1 and flush=0, capture at the end of cycle N:
    - the 2W-bit product of acc_a and acc_b: signed for op 00 and 10 (both operands sign-extended), unsigned for op 01 and 11;
    - the add/sub flag;
    - stage-1 valid=1.
  - Otherwise stage-1 valid=0.
- Stage 2 (commit cycle N+1):
  - While stage-1 valid=1, compute sum = {HI,LO} + product (MADD/MADDU) or {HI,LO} - product (MSUB/MSUBU), modulo 2^(2W). No overflow or trap.
  - The commit writes sum into {HI,LO} at the end of cycle N+1, unless flush=1 in cycle N+1, in which case the op is dropped and HI/LO are unchanged.
- busy: equals stage-1 valid. It is high exactly in cycle N+1 for each issued, unflushed op.
- Back-to-back ops (acc_valid in N and N+1):
  - Fully pipelined, no stall, no accept/ready signal.
  - The second op's stage 2 reads the HI/LO written by the first at the end of N+1.
- Direct write colliding with a commit in the same cycle:
  - The direct write is program-later, so it wins for the half it writes.
  - The half not written takes the commit result.
  - Example: we_lo with a commit gives LO=wdata_lo, HI=sum_hi.
- Direct writes while idle: HI and/or LO update at the end of the cycle. Unwritten halves hold.
- Read forwarding: rd_hi and rd_lo present the value the register will hold after the current edge, with priority:
  1. direct write data;
  2. commit sum (stage-1 valid and flush=0);
  3. stored register.
- Consequences of forwarding:
  - Reads are always architecturally correct, including in the same cycle as a write or commit.
  - A read in cycle N does not see the op issued in N; it sees that op in N+1.
- flush:
  - Kills only the accumulate path: stage 1 and any same-cycle issue.
  - Does not block direct writes presented in the same cycle.
- Timing: the multiplier sits in stage 1 only and the 2W adder in stage 2 only. No combinational path from acc_a/acc_b to rd_hi/rd_lo.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with acc_valid=1, acc_a=acc_b=7 -> rd_hi=rd_lo=0x00000000, busy=0; HI/LO remain 0 after release.
2. Direct write: we_hi=1, wdata_hi=0x12345678 -> rd_hi=0x12345678 in the same cycle; next cycle (we_hi=0) rd_hi=0x12345678, rd_lo=0x00000000.
3. Back-to-back accumulate from HI/LO=0:
   - MADD a=0xFFFFFFFF, b=2 in cycle N;
   - MADDU a=0xFFFFFFFF, b=2 in cycle N+1;
   - -> cycle N+1 rd={0xFFFFFFFF,0xFFFFFFFE}, busy=1;
   - -> cycle N+2 rd={0x00000001,0xFFFFFFFC}, busy=1;
   - -> cycle N+3 busy=0, value held.
4. MSUB from HI/LO=0, a=3, b=4 -> HI=0xFFFFFFFF, LO=0xFFFFFFF4 one cycle after issue.
5. Flush: HI/LO={0,0x10}, MADD a=5, b=5 in N, flush=1 in N+1 -> busy=1 in N+1, then 0; HI/LO stay {0x00000000,0x00000010}. Repeat with flush in N -> busy never asserts.
6. Collision: HI/LO=0, MADD a=2, b=3 in N; we_lo=1, wdata_lo=0xAAAA5555 in N+1 -> rd_lo=0xAAAA5555 and rd_hi=0x00000000 in N+1; registers hold {0x00000000,0xAAAA5555} afterwards.
